// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Latches one load/store request and sequences it onto a memory
//            that reacts only to rising read/write strobes; returns load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ADDR_W        = 18,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              byte_op,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_byte_op,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;

    localparam int         CNT_W    = 4;
    localparam logic [3:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_load_q;
    logic              sign_ext_q;
    logic              byte_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rd_q, wr_q;
    logic [31:0]       load_data_q;

    logic              w_illegal;
    logic              w_accept;
    logic              w_capture;

    assign w_illegal = (is_load == is_store) || (!byte_op && (addr[1:0] != 2'b00));
    assign w_accept  = (state_q == S_IDLE) && req && !w_illegal;
    assign w_capture = (state_q == S_STROBE) && (state_d == S_CAPTURE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = w_illegal ? S_ERROR : S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            S_ERROR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_CAPTURE) || (state_q == S_ERROR);
        err  = (state_q == S_ERROR);
    end

    // Request latch; rejected requests leave the memory-facing registers alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_load_q  <= 1'b0;
            sign_ext_q <= 1'b0;
            byte_op_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (w_accept) begin
            is_load_q  <= is_load;
            sign_ext_q <= sign_ext;
            byte_op_q  <= byte_op;
            addr_q     <= addr;
            wdata_q    <= store_data;
        end
    end

    // Strobes are registered so the memory sees a single glitch-free rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= (state_d == S_STROBE) &&  is_load_q;
            wr_q <= (state_d == S_STROBE) && !is_load_q;
        end
    end

    // Read data is taken as the strobe falls so load_data is valid alongside done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data_q <= '0;
        end else if (w_capture && is_load_q) begin
            if (byte_op_q) begin
                load_data_q <= {{24{sign_ext_q & mem_read_data[7]}}, mem_read_data[7:0]};
            end else begin
                load_data_q <= mem_read_data;
            end
        end
    end

    assign load_data      = load_data_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_byte_op    = byte_op_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Scoreboard bench for mem_access_ctrl with a byte-addressed
//            memory model; second instance covers a 3-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req, is_load, is_store, byte_op, sign_ext;
    logic [17:0] addr;
    logic [31:0] store_data;
    logic        busy, done, err;
    logic [31:0] load_data;
    logic [17:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_byte_op, mem_read, mem_write;
    logic [31:0] mem_read_data;

    logic        req3, is_load3, is_store3, byte_op3, sign_ext3;
    logic [17:0] addr3;
    logic [31:0] store_data3;
    logic        busy3, done3, err3;
    logic [31:0] load_data3;
    logic [17:0] mem_address3;
    logic [31:0] mem_write_data3;
    logic        mem_byte_op3, mem_read3, mem_write3;

    mem_access_ctrl #(.ADDR_W(18), .STROBE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .is_load(is_load), .is_store(is_store),
        .byte_op(byte_op), .sign_ext(sign_ext), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_op(mem_byte_op), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    mem_access_ctrl #(.ADDR_W(18), .STROBE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .is_load(is_load3), .is_store(is_store3),
        .byte_op(byte_op3), .sign_ext(sign_ext3), .addr(addr3), .store_data(store_data3),
        .busy(busy3), .done(done3), .err(err3), .load_data(load_data3),
        .mem_address(mem_address3), .mem_write_data(mem_write_data3),
        .mem_byte_op(mem_byte_op3), .mem_read(mem_read3), .mem_write(mem_write3),
        .mem_read_data(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory that acts only on strobe rising edges
    logic [7:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_read_data = 32'h0;
    end

    always @(posedge mem_write) begin
        if (mem_byte_op) begin
            mem[int'(mem_address[7:0])] = mem_write_data[7:0];
        end else begin
            for (int k = 0; k < 4; k++)
                mem[(int'(mem_address[7:0]) + k) % 256] = mem_write_data[8*k +: 8];
        end
    end

    always @(posedge mem_read) begin
        if (mem_byte_op) begin
            mem_read_data = {24'h0, mem[int'(mem_address[7:0])]};
        end else begin
            for (int k = 0; k < 4; k++)
                mem_read_data[8*k +: 8] = mem[(int'(mem_address[7:0]) + k) % 256];
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          rdw;
        int          wrw;
        logic        bop;
        logic [17:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: accumulates per-transaction observations, compares on done
    int   m_busy, m_rd, m_wr;
    logic m_bad;
    initial begin
        m_busy = 0; m_rd = 0; m_wr = 0; m_bad = 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 0; m_rd = 0; m_wr = 0; m_bad = 1'b0;
        end else begin
            if (busy)      m_busy++;
            if (mem_read)  m_rd++;
            if (mem_write) m_wr++;
            if (mem_read && mem_write) m_bad = 1'b1;
            if (err && !done)          m_bad = 1'b1;
            if ((mem_read || mem_write) && sb.size() > 0) begin
                if (mem_byte_op !== sb[0].bop || mem_address !== sb[0].addr) m_bad = 1'b1;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err",        {31'd0, err},  {31'd0, e.err});
                    chk("latency",    32'(m_busy),   32'(e.lat));
                    chk("rd_width",   32'(m_rd),     32'(e.rdw));
                    chk("wr_width",   32'(m_wr),     32'(e.wrw));
                    chk("load_data",  load_data,     e.ld);
                    chk("ctrl_clean", {31'd0, m_bad}, 32'd0);
                end
                m_busy = 0; m_rd = 0; m_wr = 0; m_bad = 1'b0;
            end
        end
    end

    // Issue one request; hold>0 keeps req high with unrelated fields afterwards
    task automatic issue(input logic l, input logic s, input logic b, input logic se,
                         input logic [17:0] a, input logic [31:0] d, input int hold,
                         input bit push, input logic e_err, input logic [31:0] e_ld);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b1; is_load = l; is_store = s; byte_op = b; sign_ext = se;
        addr = a; store_data = d;
        if (push) begin
            e.err  = e_err;
            e.ld   = e_ld;
            e.lat  = e_err ? 1 : 3;
            e.rdw  = (!e_err && l) ? 1 : 0;
            e.wrw  = (!e_err && s) ? 1 : 0;
            e.bop  = b;
            e.addr = a;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (hold > 0) begin
            is_load = 1'b0; is_store = 1'b1; byte_op = 1'b0;
            addr = 18'h00020; store_data = 32'hCAFEF00D;
            repeat (hold) @(posedge clk);
            #1;
        end
        req = 1'b0;
        if (push) begin
            t = 0;
            while (sb.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (sb.size() != 0) begin
                chk("done_timeout", 32'(sb.size()), 32'd0);
                sb.delete();
            end
        end
    endtask

    initial begin
        int t, w, lat;
        reset = 1'b1;
        req = 0; is_load = 0; is_store = 0; byte_op = 0; sign_ext = 0;
        addr = '0; store_data = '0;
        req3 = 0; is_load3 = 0; is_store3 = 0; byte_op3 = 0; sign_ext3 = 0;
        addr3 = '0; store_data3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_strobes",   {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_load_data", load_data,          32'd0);
        chk("rst_mem_addr",  32'(mem_address),   32'd0);
        reset = 1'b0;

        // STROBE_CYCLES=3 word store
        @(posedge clk);
        #1;
        req3 = 1'b1; is_store3 = 1'b1; addr3 = 18'h0000C; store_data3 = 32'h12345678;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        w = 0; lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_write3) w++;
            if (done3) break;
        end
        chk("sc3_latency",  32'(lat),          32'd5);
        chk("sc3_wr_width", 32'(w),            32'd3);
        chk("sc3_err",      {31'd0, err3},     32'd0);
        chk("sc3_wdata",    mem_write_data3,   32'h12345678);

        // l, s, b, se, addr, data, hold, push, err, expected load_data
        issue(0, 1, 0, 0, 18'h00008, 32'hDEADBEEF, 0, 1, 0, 32'h00000000);
        issue(1, 0, 0, 0, 18'h00008, 32'h0,        0, 1, 0, 32'hDEADBEEF);
        issue(0, 1, 1, 0, 18'h00005, 32'h12345680, 0, 1, 0, 32'hDEADBEEF);
        issue(1, 0, 1, 1, 18'h00005, 32'h0,        0, 1, 0, 32'hFFFFFF80);
        issue(1, 0, 1, 0, 18'h00005, 32'h0,        0, 1, 0, 32'h00000080);
        issue(1, 0, 0, 0, 18'h00006, 32'h0,        0, 1, 1, 32'h00000080);
        issue(1, 1, 0, 0, 18'h00000, 32'h0,        0, 1, 1, 32'h00000080);
        issue(0, 0, 1, 0, 18'h00004, 32'h0,        0, 1, 1, 32'h00000080);
        // req held through SETUP, STROBE and the done cycle must be ignored
        issue(1, 0, 0, 0, 18'h00008, 32'h0,        3, 1, 0, 32'hDEADBEEF);
        issue(1, 0, 0, 0, 18'h00020, 32'h0,        0, 1, 0, 32'h00000000);
        issue(0, 1, 0, 0, 18'h00020, 32'hCAFEF00D, 0, 1, 0, 32'h00000000);
        issue(1, 0, 0, 0, 18'h00020, 32'h0,        0, 1, 0, 32'hCAFEF00D);

        // Reset while the write strobe is high
        issue(0, 1, 0, 0, 18'h00010, 32'h00000055, 0, 0, 0, 32'h0);
        t = 0;
        while (mem_write !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("mid_wr_seen", {31'd0, mem_write}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_wr_drop",   {31'd0, mem_write}, 32'd0);
        chk("async_busy_drop", {31'd0, busy},      32'd0);
        chk("async_done_low",  {31'd0, done},      32'd0);
        chk("async_ld_clear",  load_data,          32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(1, 0, 0, 0, 18'h00008, 32'h0,        0, 1, 0, 32'hDEADBEEF);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
